parking_timer: RTL
==================

PARKING_TIMER -- requirements
Module: parking_timer

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 40_000_000, meaning input clock rate in Hz.
REQ-002 SHALL have parameter BILL_HOLD, default 5, meaning seconds the exit bill stays on display.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port park_evt  in  1  one-cycle pulse: car placed in park_slot.
REQ-006 SHALL have port park_slot  in  2  slot index being filled (FSM location).
REQ-007 SHALL have port leave_evt  in  1  one-cycle pulse: car leaving leave_slot.
REQ-008 SHALL have port leave_slot  in  2  slot index being freed.
REQ-009 SHALL have port view_slot  in  2  slot whose elapsed time is shown in time mode.
REQ-010 SHALL have port mode_btn  in  1  one-cycle pulse (debounced) requesting a display-mode toggle.
REQ-011 SHALL have port mode  out  1  0 = capacity view, 1 = time view; drives display mode.
REQ-012 SHALL have port minutes  out  6  displayed minutes, 0..59.
REQ-013 SHALL have port seconds  out  6  displayed seconds, 0..59.
REQ-014 SHALL have port bill_valid  out  1  one-cycle pulse when a bill is captured.
REQ-015 SHALL have port active  out  4  per-slot timer-running flags.

Function
REQ-016 SHALL generate an internal one-cycle tick every CLK_FREQUENCY clk cycles (count 0..CLK_FREQUENCY-1, tick at terminal count).
REQ-017 SHALL keep four slot timers (min 6b, sec 6b); on tick each active timer increments: sec 59->0 with min+1; at 59:59 it saturates.
REQ-018 SHALL, on park_evt to an inactive slot, set active and clear that timer to 00:00; a same-cycle tick is not applied to it.
REQ-019 SHALL ignore park_evt to an already-active slot (timer unchanged).
REQ-020 SHALL, on leave_evt to an active slot, capture the pre-tick timer value as the bill, clear active, pulse bill_valid next cycle.
REQ-021 SHALL ignore leave_evt to an inactive slot (no bill, no state change).
REQ-022 SHALL, for park_evt and leave_evt on the same active slot in one cycle, bill the old stay then restart that slot at 00:00 active.
REQ-023 SHALL process park_evt and leave_evt on different slots in the same cycle independently.
REQ-024 SHALL implement display FSM SHOW_CAP, SHOW_TIME, SHOW_BILL.
REQ-025 SHALL transition SHOW_CAP -> SHOW_TIME and SHOW_TIME -> SHOW_CAP on mode_btn.
REQ-026 SHALL enter SHOW_BILL from any state on a billed leave, loading a hold counter with BILL_HOLD; a new bill while in SHOW_BILL reloads it.
REQ-027 SHALL decrement the hold counter on tick and return SHOW_BILL -> SHOW_CAP when it reaches 0, or immediately on mode_btn.
REQ-028 SHALL give leave priority over mode_btn in the same cycle.
REQ-029 SHALL drive mode=0, minutes=seconds=0 in SHOW_CAP; mode=1 with view_slot timer (00:00 if inactive) in SHOW_TIME; mode=1 with captured bill in SHOW_BILL.
REQ-030 SHALL register all outputs; every event is visible on outputs one clk cycle after its input cycle.

Reset
REQ-031 SHALL, while reset is high at a clk edge, clear all timers, active=0, bill=00:00, hold counter=0, tick counter=0, state=SHOW_CAP, mode=0, minutes=0, seconds=0, bill_valid=0.
REQ-032 SHALL, on reset mid-stay or mid-bill, discard all timing with no bill_valid, ignoring all event inputs that cycle.

Structure
REQ-033 SHALL place the display-state encoding, MAX_MIN=59 and MAX_SEC=59 in a shared package.
REQ-034 SHALL instantiate one sub-module tick_gen (parameter CLK_FREQUENCY, ports clk, reset, tick) for the 1 s enable.

Verification (CLK_FREQUENCY=10, BILL_HOLD=2)
REQ-035 SHALL cover: park slot 2, 75 ticks, view_slot=2, mode_btn -> mode=1, minutes=1, seconds=15.
REQ-036 SHALL cover: park slot 0, 3700 ticks -> slot 0 saturated at minutes=59, seconds=59.
REQ-037 SHALL cover: slot 1 at 00:07, leave slot 1 with tick same cycle -> bill_valid pulse, SHOW_BILL 00:07, active[1]=0, SHOW_CAP after 2 ticks.
REQ-038 SHALL cover: leave inactive slot 3 and park active slot 0 -> no bill_valid, active and timers unchanged.
REQ-039 SHALL cover: park+leave slot 1 same cycle at 00:20 -> bill 00:20, slot 1 active at 00:00.
REQ-040 SHALL cover: reset during SHOW_BILL -> next cycle mode=0, active=0, outputs 0, no bill_valid.

Source files
------------

// File: rtl/parking_timer_pkg.sv
// -----------------------------------------------------------------------------
// parking_timer_pkg
// Shared definitions for the four-slot parking timer:
//   - display-state encoding (SHOW_CAP / SHOW_TIME / SHOW_BILL)
//   - MAX_MIN / MAX_SEC saturation limits of a slot timer
//   - mm:ss record type and its saturating one-second increment
// -----------------------------------------------------------------------------
package parking_timer_pkg;

    // Display states, kept as plain constants so older tools can share them.
    localparam logic [1:0] SHOW_CAP  = 2'd0;
    localparam logic [1:0] SHOW_TIME = 2'd1;
    localparam logic [1:0] SHOW_BILL = 2'd2;

    // Timer limits: a stay longer than 59:59 stays pinned at 59:59.
    localparam logic [5:0] MAX_MIN = 6'd59;
    localparam logic [5:0] MAX_SEC = 6'd59;

    localparam int NUM_SLOTS = 4;

    // Elapsed time of one stay.
    typedef struct packed {
        logic [5:0] mins;
        logic [5:0] secs;
    } mmss_t;

    localparam mmss_t ZERO_TIME = 12'd0;

    // Advance a timer by one second; seconds roll into minutes and the
    // whole value saturates at MAX_MIN:MAX_SEC.
    function automatic mmss_t mmss_inc(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.secs == MAX_SEC) begin
            if (t.mins == MAX_MIN) begin
                r = t;
            end else begin
                r.secs = 6'd0;
                r.mins = t.mins + 6'd1;
            end
        end else begin
            r.secs = t.secs + 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/parking_timer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Divides the system clock down to a one-cycle enable once per second.
// The counter runs 0..CLK_FREQUENCY-1; tick is high for the one cycle in
// which the counter sits at its terminal value.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  synchronous active-high reset (counter back to 0)
//   tick  out one-cycle pulse every CLK_FREQUENCY cycles (registered)
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int CLK_FREQUENCY = 40_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int             CW       = (CLK_FREQUENCY > 1) ? $clog2(CLK_FREQUENCY) : 1;
    localparam logic [CW-1:0]  TERMINAL = CW'(CLK_FREQUENCY - 1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          tick_r;

    // Next counter value with wrap at the terminal count.
    always_comb begin
        count_next_s = count_r;
        if (count_r == TERMINAL) begin
            count_next_s = {CW{1'b0}};
        end else begin
            count_next_s = count_r + CW'(1);
        end
    end

    // Counter and tick flag; tick is registered from the next count so it is
    // high exactly while count_r holds the terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            tick_r  <= (count_next_s == TERMINAL);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/parking_timer.sv
// -----------------------------------------------------------------------------
// parking_timer
// Four-slot parking timer with a three-state display.
//   - Each slot runs an mm:ss timer while occupied (1 s resolution).
//   - Leaving an occupied slot captures its elapsed time as the bill,
//     pulses bill_valid and shows the bill for BILL_HOLD seconds.
//   - mode_btn toggles between capacity view and the time of view_slot.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   park_evt, park_slot   pulse + slot index: car arrives
//   leave_evt, leave_slot pulse + slot index: car leaves
//   view_slot             slot shown in time view
//   mode_btn              debounced pulse: toggle display mode
//   mode                  0 = capacity view, 1 = time/bill view
//   minutes, seconds      displayed time
//   bill_valid            one-cycle pulse when a bill is captured
//   active                per-slot occupied/running flags
// All outputs are registered and reflect the state after the input cycle.
// -----------------------------------------------------------------------------
module parking_timer
    import parking_timer_pkg::*;
#(
    parameter int CLK_FREQUENCY = 40_000_000,
    parameter int BILL_HOLD     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       park_evt,
    input  logic [1:0] park_slot,
    input  logic       leave_evt,
    input  logic [1:0] leave_slot,
    input  logic [1:0] view_slot,
    input  logic       mode_btn,
    output logic       mode,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       bill_valid,
    output logic [3:0] active
);

    localparam int            HW        = (BILL_HOLD > 0) ? $clog2(BILL_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(BILL_HOLD);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          tick_s;
    logic [3:0]    active_r;
    mmss_t         timer_r [NUM_SLOTS];
    mmss_t         bill_r;
    logic [HW-1:0] hold_r;
    logic [1:0]    state_r;
    logic          mode_r;
    logic [5:0]    minutes_r;
    logic [5:0]    seconds_r;
    logic          bill_valid_r;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [3:0]    park_hit_s;
    logic [3:0]    leave_hit_s;
    logic          billed_s;
    logic [3:0]    active_s;
    mmss_t         timer_s [NUM_SLOTS];
    mmss_t         bill_s;
    logic [HW-1:0] hold_s;
    logic [1:0]    state_s;
    mmss_t         view_time_s;
    mmss_t         disp_s;
    logic          mode_s;

    tick_gen #(
        .CLK_FREQUENCY(CLK_FREQUENCY)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick_s)
    );

    // Decode events to per-slot hits; a leave only counts on an occupied slot.
    assign park_hit_s  = park_evt  ? (4'b0001 << park_slot)  : 4'b0000;
    assign leave_hit_s = (leave_evt ? (4'b0001 << leave_slot) : 4'b0000) & active_r;
    assign billed_s    = |leave_hit_s;

    // The bill is the timer value before any same-cycle tick is applied.
    assign bill_s = billed_s ? timer_r[leave_slot] : bill_r;

    // Per-slot timer and occupancy update.
    always_comb begin
        active_s = active_r;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            timer_s[i] = timer_r[i];
            // A park on a free slot, or on a slot vacated this same cycle,
            // starts a fresh stay; the tick is deliberately not applied.
            if (park_hit_s[i] && (!active_r[i] || leave_hit_s[i])) begin
                active_s[i] = 1'b1;
                timer_s[i]  = ZERO_TIME;
            end else if (leave_hit_s[i]) begin
                active_s[i] = 1'b0;
                timer_s[i]  = ZERO_TIME;
            end else if (active_r[i] && tick_s) begin
                timer_s[i]  = mmss_inc(timer_r[i]);
            end else begin
                timer_s[i]  = timer_r[i];
            end
        end
    end

    // Display FSM; a billed leave wins over mode_btn and re-arms the hold.
    always_comb begin
        state_s = state_r;
        hold_s  = hold_r;
        if (billed_s) begin
            state_s = SHOW_BILL;
            hold_s  = HOLD_LOAD;
        end else begin
            case (state_r)
                SHOW_CAP: begin
                    if (mode_btn) begin
                        state_s = SHOW_TIME;
                    end else begin
                        state_s = SHOW_CAP;
                    end
                end
                SHOW_TIME: begin
                    if (mode_btn) begin
                        state_s = SHOW_CAP;
                    end else begin
                        state_s = SHOW_TIME;
                    end
                end
                SHOW_BILL: begin
                    if (mode_btn) begin
                        state_s = SHOW_CAP;
                        hold_s  = {HW{1'b0}};
                    end else if (tick_s) begin
                        // Leave when the decrement reaches zero (or if the
                        // hold was zero to begin with).
                        if (hold_r <= HW'(1)) begin
                            state_s = SHOW_CAP;
                            hold_s  = {HW{1'b0}};
                        end else begin
                            state_s = SHOW_BILL;
                            hold_s  = hold_r - HW'(1);
                        end
                    end else begin
                        state_s = SHOW_BILL;
                    end
                end
                default: begin
                    state_s = SHOW_CAP;
                    hold_s  = {HW{1'b0}};
                end
            endcase
        end
    end

    // Time of the viewed slot after this cycle's update; free slots show 00:00.
    assign view_time_s = active_s[view_slot] ? timer_s[view_slot] : ZERO_TIME;

    // Display content for the next state, so outputs follow events by one cycle.
    always_comb begin
        mode_s = 1'b0;
        disp_s = ZERO_TIME;
        case (state_s)
            SHOW_CAP: begin
                mode_s = 1'b0;
                disp_s = ZERO_TIME;
            end
            SHOW_TIME: begin
                mode_s = 1'b1;
                disp_s = view_time_s;
            end
            SHOW_BILL: begin
                mode_s = 1'b1;
                disp_s = bill_s;
            end
            default: begin
                mode_s = 1'b0;
                disp_s = ZERO_TIME;
            end
        endcase
    end

    // State and output registers; reset discards every stay and pending bill.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r     <= 4'b0000;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                timer_r[i] <= ZERO_TIME;
            end
            bill_r       <= ZERO_TIME;
            hold_r       <= {HW{1'b0}};
            state_r      <= SHOW_CAP;
            mode_r       <= 1'b0;
            minutes_r    <= 6'd0;
            seconds_r    <= 6'd0;
            bill_valid_r <= 1'b0;
        end else begin
            active_r     <= active_s;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                timer_r[i] <= timer_s[i];
            end
            bill_r       <= bill_s;
            hold_r       <= hold_s;
            state_r      <= state_s;
            mode_r       <= mode_s;
            minutes_r    <= disp_s.mins;
            seconds_r    <= disp_s.secs;
            bill_valid_r <= billed_s;
        end
    end

    assign mode       = mode_r;
    assign minutes    = minutes_r;
    assign seconds    = seconds_r;
    assign bill_valid = bill_valid_r;
    assign active     = active_r;

endmodule
